// File: rtl/aes_pkg.sv
// Shared AES-block package: arbiter state encoding and default arbiter sizing.
package aes_pkg;

  localparam int unsigned DefaultNumReq        = 4;
  localparam int unsigned DefaultTimeoutCycles = 1023;

  // 4-bit encoding to line up with the engine controller's state enums.
  typedef enum logic [3:0] {
    StArbIdle  = 4'd0,
    StIssue    = 4'd1,
    StWaitBusy = 4'd2,
    StWaitDone = 4'd3,
    StRelease  = 4'd4
  } arb_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module aes_rr_pick #(
  parameter int unsigned  NumReq = 4,
  localparam int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    id_o,
  output logic              valid_o
);

  logic           found;
  logic [IdW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdW'((32'(ptr_i) + i) % NumReq);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter for the shared AES engine; key-change jobs win over data jobs.
// Define AES_ARB_TIMEOUT_EN to build the busy-period watchdog.
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned  NUM_REQ        = DefaultNumReq,
  parameter int unsigned  TIMEOUT_CYCLES = DefaultTimeoutCycles,
  localparam int unsigned IdW            = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_chg_key,
  input  logic               core_idle,
  output logic               core_start,
  output logic               core_change_key,
  output logic [NUM_REQ-1:0] grant,
  output logic [IdW-1:0]     grant_id,
  output logic [NUM_REQ-1:0] job_done,
  output logic               busy,
  output logic               timeout_err
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] grant_q, job_done_q;
  logic [IdW-1:0]     grant_id_q, last_id_q;
  logic               chg_q, start_q, busy_q, timeout_q;

  logic [NUM_REQ-1:0] key_req, pick_req, pick_gnt;
  logic [IdW-1:0]     pick_id, ptr;
  logic               key_any, pick_valid, wd_expired;

  assign key_req  = req & req_chg_key;
  assign key_any  = |key_req;
  assign pick_req = key_any ? key_req : req;
  assign ptr      = (last_id_q == IdW'(NUM_REQ - 1)) ? '0 : last_id_q + IdW'(1);

  aes_rr_pick #(
    .NumReq (NUM_REQ)
  ) u_pick (
    .req_i   (pick_req),
    .ptr_i   (ptr),
    .gnt_o   (pick_gnt),
    .id_o    (pick_id),
    .valid_o (pick_valid)
  );

`ifdef AES_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wd_cnt_q;

  // Counts only while staying in a wait state, so every wait-state entry restarts at zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_cnt_q <= '0;
    end else if ((state_q == StWaitBusy && core_idle) || (state_q == StWaitDone && !core_idle)) begin
      wd_cnt_q <= wd_cnt_q + CntW'(1);
    end else begin
      wd_cnt_q <= '0;
    end
  end

  assign wd_expired = ((state_q == StWaitBusy) || (state_q == StWaitDone)) &&
                      (wd_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expired         = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StArbIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_id_q  <= IdW'(NUM_REQ - 1);
      chg_q      <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      job_done_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      start_q    <= 1'b0;
      job_done_q <= '0;
      timeout_q  <= 1'b0;
      case (state_q)
        StArbIdle: begin
          if (pick_valid && core_idle) begin
            grant_q    <= pick_gnt;
            grant_id_q <= pick_id;
            chg_q      <= key_any;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          start_q <= 1'b1;
          state_q <= StWaitBusy;
        end
        StWaitBusy: begin
          if (!core_idle) begin
            state_q <= StWaitDone;
          end else if (wd_expired) begin
            job_done_q <= grant_q;
            timeout_q  <= 1'b1;
            state_q    <= StRelease;
          end
        end
        StWaitDone: begin
          if (core_idle) begin
            job_done_q <= grant_q;
            state_q    <= StRelease;
          end else if (wd_expired) begin
            job_done_q <= grant_q;
            timeout_q  <= 1'b1;
            state_q    <= StRelease;
          end
        end
        StRelease: begin
          last_id_q  <= grant_id_q;
          grant_q    <= '0;
          grant_id_q <= '0;
          chg_q      <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StArbIdle;
        end
        default: state_q <= StArbIdle;
      endcase
    end
  end

  assign core_start      = start_q;
  assign core_change_key = chg_q;
  assign grant           = grant_q;
  assign grant_id        = grant_id_q;
  assign job_done        = job_done_q;
  assign busy            = busy_q;
  assign timeout_err     = timeout_q;

endmodule
